// File: rtl/trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// trap_ctrl_if : bus between the control unit / datapath and the trap sequencer.
//
// Signals (direction as seen by trap_ctrl, the slave):
//   exc_check   in   one-cycle strobe; exception flags are valid this cycle
//   exc_opcode  in   invalid-opcode flag
//   exc_ovf     in   ALU overflow flag
//   pc_in       in   current PC (already +4)
//   mem_rdata   in   data-memory read byte
//   mem_addr    out  data-memory address used for the vector read
//   mem_rd      out  data-memory read request
//   pc_next     out  handler address (vector byte, zero-extended)
//   pc_load     out  one-cycle PC write strobe
//   epc         out  exception PC register
//   causa       out  cause register: 0 = opcode, 1 = overflow
//   stall       out  holds the control unit while a trap is in flight
//   trap_state  out  FSM state, for monitoring
// ---------------------------------------------------------------------------
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            exc_check;
  logic            exc_opcode;
  logic            exc_ovf;
  logic [XLEN-1:0] pc_in;
  logic [7:0]      mem_rdata;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic [XLEN-1:0] epc;
  logic            causa;
  logic            stall;
  logic [2:0]      trap_state;

  // Seen from the control unit / datapath side.
  modport master (
    output exc_check, exc_opcode, exc_ovf, pc_in, mem_rdata,
    input  mem_addr, mem_rd, pc_next, pc_load, epc, causa, stall, trap_state
  );

  // Seen from the trap sequencer.
  modport slave (
    input  exc_check, exc_opcode, exc_ovf, pc_in, mem_rdata,
    output mem_addr, mem_rd, pc_next, pc_load, epc, causa, stall, trap_state
  );
endinterface

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl : multicycle exception sequencer.
//
// On an exception reported by the control unit it latches cause and EPC,
// stalls the control unit, reads the handler byte from a fixed vector slot
// in data memory and loads the PC with it (zero-extended).
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave side of trap_ctrl_if (see that file for the signal list)
//
// Timeline for a trap whose exc_check pulse is in cycle 0:
//   cycle 1            CAPTURE  epc/causa/mem_addr latched at its end
//   cycle 2            READ     mem_rd starts
//   cycles 3..MEM_LAT+1 WAIT    mem_rd held
//   cycle MEM_LAT+2    LOAD     pc_load, pc_next already valid
//   cycle MEM_LAT+3    DONE     last stall cycle
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN         = 64,
  parameter int MEM_LAT      = 1,    // 1..7
  parameter int VEC_ADDR_OPC = 254,
  parameter int VEC_ADDR_OVF = 255
) (
  input  logic     clk,
  input  logic     reset,
  trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_LOAD    = 3'd4,
    ST_DONE    = 3'd5,
    ST_RSV6    = 3'd6,
    ST_RSV7    = 3'd7
  } state_e;

  state_e          state_q,   state_d;
  logic [2:0]      cnt_q,     cnt_d;
  logic [XLEN-1:0] epc_q,     epc_d;
  logic            causa_q,   causa_d;
  logic [XLEN-1:0] addr_q,    addr_d;
  logic [XLEN-1:0] pc_next_q, pc_next_d;

  logic [XLEN-1:0] rdata_ext;
  assign rdata_ext = {{(XLEN-8){1'b0}}, bus.mem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      epc_q     <= '0;
      causa_q   <= 1'b0;
      addr_q    <= '0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      causa_q   <= causa_d;
      addr_q    <= addr_d;
      pc_next_q <= pc_next_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    causa_d   = causa_q;
    addr_d    = addr_q;
    pc_next_d = pc_next_q;

    case (state_q)
      ST_IDLE: begin
        // Flags are only meaningful on the exc_check strobe.
        if (bus.exc_check && (bus.exc_opcode || bus.exc_ovf)) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        epc_d   = bus.pc_in - XLEN'(4);
        // Opcode wins when both flags are set.
        causa_d = ~bus.exc_opcode;
        addr_d  = bus.exc_opcode ? XLEN'(VEC_ADDR_OPC) : XLEN'(VEC_ADDR_OVF);
        state_d = ST_READ;
      end

      ST_READ: begin
        cnt_d = 3'(MEM_LAT - 1);
        if (MEM_LAT == 1) begin
          // Single-cycle memory: the byte is valid at the end of READ.
          pc_next_d = rdata_ext;
          state_d   = ST_LOAD;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Counter reaches 0 on the last read cycle; capture the byte then.
        if (cnt_q <= 3'd1) begin
          cnt_d     = 3'd0;
          pc_next_d = rdata_ext;
          state_d   = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_LOAD: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        // Encodings 6/7 are never entered normally; recover to IDLE.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode directly from state; everything else is a register.
  assign bus.mem_rd     = (state_q == ST_READ) || (state_q == ST_WAIT);
  assign bus.pc_load    = (state_q == ST_LOAD);
  assign bus.stall      = (state_q != ST_IDLE);
  assign bus.trap_state = state_q;
  assign bus.mem_addr   = addr_q;
  assign bus.epc        = epc_q;
  assign bus.causa      = causa_q;
  assign bus.pc_next    = pc_next_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl : two trap_ctrl instances (MEM_LAT = 1 and 3) driven with the
// same stimulus and compared every cycle against a timeline model: a trap
// accepted in cycle t has its behaviour described purely by the offset
// k = cycle - t.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            exc_check;
  logic            exc_opcode;
  logic            exc_ovf;
  logic [XLEN-1:0] pc_in;
  logic [7:0]      mem_rdata;

  int n_assert;
  int n_fail;

  trap_ctrl_if #(.XLEN(XLEN)) bus1 ();
  trap_ctrl_if #(.XLEN(XLEN)) bus3 ();

  assign bus1.exc_check  = exc_check;
  assign bus1.exc_opcode = exc_opcode;
  assign bus1.exc_ovf    = exc_ovf;
  assign bus1.pc_in      = pc_in;
  assign bus1.mem_rdata  = mem_rdata;
  assign bus3.exc_check  = exc_check;
  assign bus3.exc_opcode = exc_opcode;
  assign bus3.exc_ovf    = exc_ovf;
  assign bus3.pc_in      = pc_in;
  assign bus3.mem_rdata  = mem_rdata;

  trap_ctrl #(.XLEN(XLEN), .MEM_LAT(1), .VEC_ADDR_OPC(254), .VEC_ADDR_OVF(255))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  trap_ctrl #(.XLEN(XLEN), .MEM_LAT(3), .VEC_ADDR_OPC(254), .VEC_ADDR_OVF(255))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int              lat [2] = '{1, 3};
  bit              m_act [2];
  int              m_k [2];
  logic [XLEN-1:0] m_epc [2];
  logic            m_causa [2];
  logic [XLEN-1:0] m_addr [2];
  logic [XLEN-1:0] m_pcn [2];
  int              n_pcload [2];

  function automatic int exp_state(int i);
    if (!m_act[i])                return 0;
    if (m_k[i] == 1)              return 1;
    if (m_k[i] == 2)              return 2;
    if (m_k[i] <= lat[i] + 1)     return 3;
    if (m_k[i] == lat[i] + 2)     return 4;
    return 5;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_epc[i] = '0; m_causa[i] = 0;
      m_addr[i] = '0; m_pcn[i] = '0;
    end
  endtask

  // Advance one clock edge using the input values present before the edge.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_act[i] = 0; m_k[i] = 0; m_epc[i] = '0; m_causa[i] = 0;
        m_addr[i] = '0; m_pcn[i] = '0;
      end else if (m_act[i]) begin
        if (m_k[i] == 1) begin
          m_epc[i]   = pc_in - 64'd4;
          m_causa[i] = exc_opcode ? 1'b0 : 1'b1;
          m_addr[i]  = exc_opcode ? 64'd254 : 64'd255;
        end
        if (m_k[i] == lat[i] + 1) m_pcn[i] = {56'd0, mem_rdata};
        if (m_k[i] == lat[i] + 3) m_act[i] = 0;
        else                      m_k[i]++;
      end else if (exc_check && (exc_opcode || exc_ovf)) begin
        m_act[i] = 1;
        m_k[i]   = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(string nm, int i, logic [2:0] st, logic stl, logic rd,
                         logic ld, logic [XLEN-1:0] addr, logic [XLEN-1:0] ep,
                         logic ca, logic [XLEN-1:0] pcn);
    bit e_rd;
    bit e_ld;
    e_rd = m_act[i] && (m_k[i] >= 2) && (m_k[i] <= lat[i] + 1);
    e_ld = m_act[i] && (m_k[i] == lat[i] + 2);
    if (ld) n_pcload[i]++;
    chk({nm, ".state"},    64'(st),  64'(exp_state(i)));
    chk({nm, ".stall"},    64'(stl), 64'(m_act[i]));
    chk({nm, ".mem_rd"},   64'(rd),  64'(e_rd));
    chk({nm, ".pc_load"},  64'(ld),  64'(e_ld));
    chk({nm, ".mem_addr"}, addr,     m_addr[i]);
    chk({nm, ".epc"},      ep,       m_epc[i]);
    chk({nm, ".causa"},    64'(ca),  64'(m_causa[i]));
    chk({nm, ".pc_next"},  pcn,      m_pcn[i]);
  endtask

  task automatic check_all();
    chk_dut("L1", 0, bus1.trap_state, bus1.stall, bus1.mem_rd, bus1.pc_load,
            bus1.mem_addr, bus1.epc, bus1.causa, bus1.pc_next);
    chk_dut("L3", 1, bus3.trap_state, bus3.stall, bus3.mem_rd, bus3.pc_load,
            bus3.mem_addr, bus3.epc, bus3.causa, bus3.pc_next);
  endtask

  // Caller sets inputs at posedge+1; check mid-cycle, clock, update model.
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
    mem_rdata = 8'($urandom);
  endtask

  task automatic idle(int n);
    exc_check = 0; exc_opcode = 0; exc_ovf = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Pulse exc_check for one cycle, keep flags/pc_in through CAPTURE.
  task automatic trap(logic [XLEN-1:0] pc, logic opc, logic ovf);
    pc_in = pc; exc_opcode = opc; exc_ovf = ovf; exc_check = 1;
    $display("trap: pc_in=%0h opcode=%0d ovf=%0d", pc, opc, ovf);
    cycle();
    exc_check = 0;
    cycle();
    exc_opcode = 0; exc_ovf = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    model_clear();
    #1;
    check_all();
    $display("reset asserted mid-cycle");
    for (int i = 0; i < 2; i++) cycle();
    reset = 1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    n_pcload[0] = 0; n_pcload[1] = 0;
    reset = 0; exc_check = 0; exc_opcode = 0; exc_ovf = 0;
    pc_in = '0; mem_rdata = 8'h00;
    model_clear();
    #2;
    check_all();                      // reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    idle(2);

    // Invalid opcode.
    trap(64'h108, 1, 0);
    idle(8);
    chk("t1.epc", bus1.epc, 64'h104);
    chk("t1.causa", 64'(bus1.causa), 64'd0);
    chk("t1.addr", bus1.mem_addr, 64'd254);

    // Overflow.
    trap(64'h20, 0, 1);
    idle(8);
    chk("t2.epc", bus3.epc, 64'h1C);
    chk("t2.addr", bus3.mem_addr, 64'd255);

    // Both flags: opcode has priority.
    trap(64'h3000, 1, 1);
    idle(8);
    chk("t3.causa", 64'(bus3.causa), 64'd0);

    // Nested exc_check during READ and WAIT is dropped.
    n_pcload[0] = 0; n_pcload[1] = 0;
    trap(64'h400, 1, 0);
    pc_in = 64'h9990; exc_ovf = 1; exc_check = 1;
    $display("nested exc_check during READ");
    cycle();
    exc_check = 0; cycle();
    exc_check = 1; cycle();
    exc_check = 0; exc_ovf = 0;
    idle(8);
    chk("nest.pcload1", 64'(n_pcload[0]), 64'd1);
    chk("nest.pcload3", 64'(n_pcload[1]), 64'd1);
    chk("nest.epc", bus3.epc, 64'h3FC);

    // Flags without strobe for 10 cycles.
    exc_opcode = 1; exc_ovf = 1; exc_check = 0;
    $display("flags without exc_check");
    for (int i = 0; i < 10; i++) cycle();
    idle(2);

    // Reset during WAIT of the MEM_LAT=3 instance.
    trap(64'h5000, 0, 1);
    cycle();                          // L3 now in WAIT
    n_pcload[0] = 0; n_pcload[1] = 0;
    pulse_reset();
    idle(10);
    chk("rst.pcload3", 64'(n_pcload[1]), 64'd0);
    chk("rst.epc", bus3.epc, 64'd0);

    // PC wrap: 0 - 4.
    trap(64'h0, 1, 0);
    idle(8);
    chk("wrap.epc", bus3.epc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic.
    $display("random phase");
    for (int i = 0; i < 400; i++) begin
      exc_check  = ($urandom_range(0, 5) == 0);
      exc_opcode = 1'($urandom_range(0, 1));
      exc_ovf    = 1'($urandom_range(0, 1));
      pc_in      = {$urandom, $urandom};
      cycle();
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multicycle exception sequencer inside the RISC-V core, directly downstream of the control unit's exception detection (invalid opcode, ALU overflow) and upstream of PC load and data-memory address muxing.
- On a detected exception it:
  - latches the cause and EPC,
  - stalls the control unit,
  - reads the handler address byte from a fixed memory vector slot,
  - loads the PC with that byte zero-extended.
- Exposes its FSM state and cause register for the simulation bench.

Parameters:
XLEN, 64, datapath/PC width
MEM_LAT, 1, data-memory read latency in cycles (1..7)
VEC_ADDR_OPC, 254, vector slot byte address for invalid-opcode trap
VEC_ADDR_OVF, 255, vector slot byte address for overflow trap

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
exc_check  in  1  one-cycle pulse from control unit at the cycle exception flags are valid
exc_opcode  in  1  invalid opcode flag
exc_ovf  in  1  ALU overflow flag
pc_in  in  XLEN  current PC (already incremented by 4)
mem_rdata  in  8  data-memory read byte
mem_addr  out  XLEN  data-memory address during vector read
mem_rd  out  1  data-memory read request
pc_next  out  XLEN  handler address
pc_load  out  1  one-cycle PC write strobe
epc  out  XLEN  exception PC register
causa  out  1  cause register: 0 = opcode, 1 = overflow
stall  out  1  holds control unit while not IDLE
trap_state  out  3  FSM state encoding, for monitoring

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - epc = 0, causa = 0, pc_next = 0, mem_addr = 0.
  - mem_rd = 0, pc_load = 0, stall = 0.
  - Wait counter = 0.
- State encodings:
  - IDLE = 0, CAPTURE = 1, READ = 2, WAIT = 3, LOAD = 4, DONE = 5.
  - 6 and 7 are unreachable; if entered, go to IDLE next cycle.
- IDLE:
  - Flags are ignored unless exc_check = 1.
  - On exc_check = 1 with either flag set: go to CAPTURE; stall = 1 from the next cycle on.
  - Flags set without exc_check: no action.
- CAPTURE (1 cycle):
  - epc <= pc_in − 4, modulo 2^XLEN. pc_in = 0 gives all-ones−3.
  - causa <= 0 if exc_opcode, else 1. Opcode has priority when both flags are set.
  - mem_addr <= VEC_ADDR_OPC or VEC_ADDR_OVF accordingly, zero-extended.
- READ (1 cycle):
  - mem_rd = 1.
  - Counter loads MEM_LAT − 1.
  - Go to WAIT, or directly to LOAD if MEM_LAT = 1.
- WAIT:
  - mem_rd held 1.
  - Counter decrements each cycle; go to LOAD when it reaches 0.
- LOAD (1 cycle):
  - pc_next <= {XLEN−8 zeros, mem_rdata}, sampled on entry to LOAD.
  - pc_load = 1 for exactly this cycle; mem_rd = 0.
- DONE (1 cycle):
  - stall = 0 at the end of this cycle; return to IDLE.
- Total latency from the exc_check pulse to pc_load: MEM_LAT + 2 cycles.
- stall is 1 in CAPTURE through DONE inclusive.
- exc_check arriving while not IDLE is ignored. The cause/EPC of the in-flight trap are not overwritten, so nested traps are dropped.
- epc, causa and pc_next hold their values after the trap until the next trap. They are cleared only by reset.
- Reset asserted mid-sequence aborts immediately to the reset values; no pc_load is emitted afterwards.
- All outputs are registered except mem_rd, pc_load and stall, which decode from state.

Test Plan:
- Invalid opcode, MEM_LAT = 1: pc_in = 0x108, exc_opcode = 1, exc_check pulse, mem_rdata = 0x40 → causa = 0, epc = 0x104, mem_addr = 254, pc_load high 3 cycles after the pulse, pc_next = 0x40, stall low after DONE.
- Overflow, MEM_LAT = 3: pc_in = 0x20, exc_ovf = 1, mem_rdata = 0x80 → causa = 1, epc = 0x1C, mem_addr = 255, mem_rd high 3 cycles, pc_load 5 cycles after the pulse, pc_next = 0x80.
- Both flags set: exc_opcode = 1, exc_ovf = 1 → causa = 0, mem_addr = 254.
- Second exc_check during READ with exc_ovf = 1 and a different pc_in → epc and causa unchanged, only one pc_load pulse.
- Flags set without exc_check for 10 cycles → state stays IDLE, stall = 0, no mem_rd.
- Reset pulled low during WAIT → all outputs 0 immediately; after release, state = IDLE and no pc_load pulse ever appears; epc = 0 and pc_in = 0 trap gives epc = 0xFFFFFFFFFFFFFFFC.
